// File: rtl/iscas_stim_gen_if.sv
// Bench/control side of the ISCAS stimulus generator.
// Carries run control, CUT stimulus/response and the MISR signature.
interface iscas_stim_gen_if #(
  parameter int N_IN  = 33,
  parameter int N_OUT = 25
);
  logic             start;
  logic [1:0]       mode;
  logic [15:0]      pattern_count;
  logic [N_OUT-1:0] resp;
  logic [N_IN-1:0]  stim;
  logic             busy;
  logic             done;
  logic [N_OUT-1:0] signature;

  modport master (
    output start,
    output mode,
    output pattern_count,
    output resp,
    input  stim,
    input  busy,
    input  done,
    input  signature
  );

  modport slave (
    input  start,
    input  mode,
    input  pattern_count,
    input  resp,
    output stim,
    output busy,
    output done,
    output signature
  );
endinterface

// File: rtl/iscas_stim_gen.sv
// Pattern generator (toggle/count/LFSR/hold) driving an ISCAS CUT,
// with a MISR folding the CUT response into a signature.
module iscas_stim_gen #(
  parameter int              N_IN      = 33,
  parameter int              N_OUT     = 25,
  parameter int              STEP_CYC  = 2,
  parameter int              CAP_LAT   = 1,
  parameter logic [N_IN-1:0] LFSR_SEED = N_IN'(1),
  parameter logic [N_IN-1:0] LFSR_TAPS = N_IN'(64'h1_0008_0000),
  parameter logic [N_OUT-1:0] MISR_TAPS = N_OUT'(64'h100_0007)
) (
  input logic clk,
  input logic reset,
  iscas_stim_gen_if.slave bus
);

  localparam int SW = (STEP_CYC > 1) ? $clog2(STEP_CYC) : 1;
  localparam int IW = $clog2(N_IN);

  localparam logic [1:0] M_TOG  = 2'd0;
  localparam logic [1:0] M_CNT  = 2'd1;
  localparam logic [1:0] M_LFSR = 2'd2;
  localparam logic [1:0] M_HOLD = 2'd3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e state_q, state_d;

  logic [SW-1:0]    step_q, step_d;
  logic [15:0]      pat_q, pat_d;
  logic [15:0]      cnt_q, cnt_d;
  logic [1:0]       mode_q, mode_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic [N_IN-1:0]  stim_q, stim_d;
  logic [N_OUT-1:0] sig_q, sig_d;

  logic             start_ok;
  logic             last_step;
  logic             last_pat;
  logic             cap_step;
  logic [N_IN-1:0]  pat0;
  logic [N_IN-1:0]  pat_nxt;
  logic [N_OUT-1:0] misr_nxt;

  assign start_ok  = bus.start && (state_q != RUN);
  assign last_step = (step_q == SW'(STEP_CYC - 1));
  assign last_pat  = (pat_q == cnt_q - 16'd1);
  assign cap_step  = (step_q == SW'(CAP_LAT));

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE, DONE: begin
        if (bus.start) begin
          state_d = (bus.pattern_count != 16'd0) ? RUN : DONE;
        end
      end
      RUN: begin
        if (last_step && last_pat) begin
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.busy = (state_q == RUN);
    bus.done = (state_q == DONE);
  end

  always_comb begin
    pat0 = '0;
    unique case (bus.mode)
      M_LFSR:  pat0 = LFSR_SEED;
      M_HOLD:  pat0 = stim_q;
      default: pat0 = '0;
    endcase
  end

  always_comb begin
    pat_nxt = stim_q;
    unique case (mode_q)
      M_TOG:   pat_nxt = stim_q ^ (N_IN'(1) << idx_q);
      M_CNT:   pat_nxt = stim_q + N_IN'(1);
      M_LFSR:  pat_nxt = {stim_q[N_IN-2:0], ^(stim_q & LFSR_TAPS)};
      default: pat_nxt = stim_q;
    endcase
  end

  assign misr_nxt = {sig_q[N_OUT-2:0], ^(sig_q & MISR_TAPS)} ^ bus.resp;

  always_comb begin
    step_d = step_q;
    pat_d  = pat_q;
    cnt_d  = cnt_q;
    mode_d = mode_q;
    idx_d  = idx_q;
    stim_d = stim_q;
    sig_d  = sig_q;
    if (start_ok) begin
      sig_d = '0;
      if (bus.pattern_count != 16'd0) begin
        mode_d = bus.mode;
        cnt_d  = bus.pattern_count;
        step_d = '0;
        pat_d  = '0;
        idx_d  = '0;
        stim_d = pat0;
      end
    end else if (state_q == RUN) begin
      if (cap_step) begin
        sig_d = misr_nxt;
      end
      if (!last_step) begin
        step_d = step_q + SW'(1);
      end else begin
        step_d = '0;
        // The final pattern stays on stim after the run ends.
        if (!last_pat) begin
          pat_d  = pat_q + 16'd1;
          stim_d = pat_nxt;
          if (mode_q == M_TOG) begin
            idx_d = (idx_q == IW'(N_IN - 1)) ? '0 : idx_q + IW'(1);
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      step_q <= '0;
      pat_q  <= '0;
      cnt_q  <= '0;
      mode_q <= '0;
      idx_q  <= '0;
      stim_q <= '0;
      sig_q  <= '0;
    end else begin
      step_q <= step_d;
      pat_q  <= pat_d;
      cnt_q  <= cnt_d;
      mode_q <= mode_d;
      idx_q  <= idx_d;
      stim_q <= stim_d;
      sig_q  <= sig_d;
    end
  end

  assign bus.stim      = stim_q;
  assign bus.signature = sig_q;

endmodule
